dac_seq_ctrl: RTL and testbench
===============================

# dac_seq_ctrl

Sequencer and arbiter for the N-bit real-number-modelled DAC. Two requesters submit target codes. A round-robin arbiter grants one request at a time, and the block then drives the DAC code input `q`. With the slew feature enabled, `q` moves toward the target one LSB at a time, holding for a settle period after each step. The block also produces the expected real-valued DAC output, so benches and formal properties can compare it against the DAC model.

## Interface
- `N`, 3: DAC code width.
- `SETTLE`, 4: settle cycles held after each code update. Must be at least 1.
- `VSUP`, 1.0 (real): DAC full-scale supply.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `req`  in  2: level requests; bit 0 is requester A, bit 1 is requester B. A requester holds its request until granted.
- `code_a`  in  N: target code from A. Sampled in the cycle A is granted.
- `code_b`  in  N: target code from B. Sampled in the cycle B is granted.
- `gnt`  out  2: one-hot grant, one-cycle pulse.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when `q` reaches the target and the last settle period has elapsed.
- `q`  out  N: registered DAC code.
- `vout_exp`  out  real: expected DAC output, equal to `q * VSUP / 2**N`. Combinational from `q`.

## Operation
- States: IDLE, MOVE, SETTLE, DONE.
- IDLE, when `req` is nonzero:
  - Pick a winner by round-robin. The last winner has the lower priority; after reset, A has priority.
  - Register `gnt[w]`, set `target <= code_w`, update the round-robin pointer, and go to MOVE.
  - With only one request pending, that request wins regardless of the pointer.
- MOVE:
  - If `q == target`: go to DONE.
  - Otherwise: set `q <= step(q, target)`, set `cnt <= SETTLE-1`, and go to SETTLE.
- SETTLE: decrement `cnt`; when `cnt == 0`, go to MOVE.
- DONE: pulse `done`, then go to IDLE.
- Requests while busy:
  - A request raised while busy is not granted and its code is not sampled. It stays pending and competes at the next IDLE cycle.
  - A request dropped before grant is forgotten.
- Arithmetic:
  - `q` moves up or down by exactly 1 per step and never wraps. From `'1` the only step is down; from `'0` the only step is up.
  - `target` is unsigned N-bit.
  - `vout_exp` uses real division, so code `'1` gives `(2**N-1)*VSUP/2**N`.
- Reset (any cycle, including mid-ramp):
  - Next edge: state IDLE, `q=0`, `target=0`, `cnt=0`, round-robin pointer to A.
  - Outputs: `gnt=0`, `busy=0`, `done=0`, `vout_exp=0.0`.
  - The in-flight transaction is abandoned with no `done`.

## Timing
- Grant: `gnt` is high in the cycle after `req` is first seen in IDLE. `busy` rises in the same cycle.
- Steps: each step takes 1 MOVE cycle plus SETTLE cycles. `q` changes on the edge leaving MOVE.
- Latency: for a distance of D codes with slew enabled, `done` is asserted `1 + D*(SETTLE+1) + 1` cycles after the grant cycle.
- D = 0: `done` comes 2 cycles after the grant cycle (MOVE, then DONE) and `q` is unchanged.
- Back-to-back: `busy` falls in the cycle after `done`. The earliest next `gnt` is 2 cycles after `done`, via one IDLE sampling cycle.

## Configuration
- `DAC_SLEW_EN` defined: `step()` moves `q` by ±1 LSB per MOVE.
- Not defined: `step()` returns `target`, so any nonzero distance completes in one MOVE+SETTLE. Latency is `1 + (SETTLE+1) + 1` cycles.

## Structure
- Package `dac_pkg`:
  - `dac_state_t` enum (IDLE, MOVE, SETTLE, DONE).
  - Requester index type.
  - Function `code_to_volt(code, vsup, n)` returning real.
- Sub-module `rr_arb2`: two-input round-robin arbiter with a registered pointer. Inputs are `req`, an enable (IDLE), and `rst`; outputs are a one-hot winner and the index.
- `cnt` width: `$clog2(SETTLE+1)`.

## Test plan
All scenarios use N=3, SETTLE=4, VSUP=1.0.
- Reset: `rst` high for 2 cycles → `q=0`, `vout_exp=0.0`, `busy=0`, `gnt=0`, `done=0`.
- Single ramp: slew on, `req[0]`, `code_a=3` → `gnt=01`. `q` goes 1, 2, 3 at 5-cycle spacing. `done` comes 17 cycles after the grant, with `vout_exp=0.375`.
- Contention: `req=11` in the same cycle, `code_a=7`, `code_b=2` → A is granted first and `q` reaches 7 (0.875). Then B is granted and `q` ramps down to 2 (0.25); `q` never exceeds 7.
- No-op: `q=5`, request with `code_b=5` → `done` 2 cycles after the grant, `q` stays 5.
- Reset mid-ramp: reset at `q=2` while ramping to 6 → next cycle `q=0`, `busy=0`, no `done`. A still-held `req` is re-granted with A priority.
- Slew off: `code_a=7` → `q=7` one cycle after the grant and `done` 7 cycles after the grant.

Source files
------------

// File: rtl/dac_pkg.sv
// dac_pkg
// Shared types and helpers for the DAC sequencer:
//   dac_state_t  : sequencer FSM states (idle, move, settle, done)
//   req_idx_t    : requester index (0 = requester A, 1 = requester B)
//   code_to_volt : ideal DAC transfer, code * vsup / 2**n
// The state literals carry an S_ prefix so they cannot collide with the
// SETTLE parameter of the sequencer.
package dac_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } dac_state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_A = 1'b0;
  localparam req_idx_t REQ_B = 1'b1;

  // Real division, so the top code gives (2**n-1)/2**n of full scale.
  function automatic real code_to_volt(input int unsigned code,
                                       input real         vsup,
                                       input int unsigned n);
    return real'(code) * vsup / real'(64'd1 << n);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-input round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst : clock and synchronous active-high reset (pointer -> A)
//   en       : arbitration is live this cycle (pointer advances on a win)
//   req[1:0] : bit 0 = requester A, bit 1 = requester B
//   win[1:0] : one-hot winner (combinational)
//   idx      : index of the winner (0 = A, 1 = B)
module rr_arb2
  import dac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] win,
  output logic       idx
);

  // High when B holds priority, i.e. A won the previous arbitration.
  logic ptr;

  always_comb begin
    win = 2'b00;
    idx = REQ_A;
    case (req)
      2'b01: begin win = 2'b01; idx = REQ_A; end
      2'b10: begin win = 2'b10; idx = REQ_B; end
      2'b11: begin
        if (ptr) begin
          win = 2'b10;
          idx = REQ_B;
        end else begin
          win = 2'b01;
          idx = REQ_A;
        end
      end
      default: begin win = 2'b00; idx = REQ_A; end
    endcase
  end

  // The last winner drops to the lower priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (en && (req != 2'b00)) begin
      ptr <= ~idx;
    end
  end

endmodule

// File: rtl/dac_seq_ctrl.sv
// dac_seq_ctrl
// Sequencer/arbiter driving the code input of an N-bit DAC. Two requesters
// post target codes; a round-robin arbiter grants one at a time and the FSM
// walks q toward the granted target, holding SETTLE cycles after each
// update, then pulses done.
// Optional feature macro: DAC_SLEW_EN -- when defined, q moves one LSB per
// step; otherwise q jumps straight to the target in a single step.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   req[1:0]       : level requests (bit 0 = A, bit 1 = B), held until granted
//   code_a, code_b : target codes, sampled in the granting IDLE cycle
//   gnt[1:0]       : one-hot grant pulse
//   busy           : transaction in progress (stays high through done)
//   done           : one-cycle pulse once the target is reached and settled
//   q              : registered DAC code
//   vout_exp       : expected DAC output voltage, combinational from q
module dac_seq_ctrl
  import dac_pkg::*;
#(
  parameter int  N      = 3,
  parameter int  SETTLE = 4,
  parameter real VSUP   = 1.0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [N-1:0] code_a,
  input  logic [N-1:0] code_b,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output real          vout_exp
);

  localparam int              CNT_W    = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  dac_state_t       state;
  logic [N-1:0]     target;
  logic [CNT_W-1:0] cnt;
  logic             arb_en;
  logic [1:0]       win;
  logic             win_idx;

  // One code update toward the target; never wraps at either rail.
  function automatic logic [N-1:0] step(input logic [N-1:0] cur,
                                        input logic [N-1:0] tgt);
`ifdef DAC_SLEW_EN
    if (tgt > cur)      return cur + N'(1);
    else if (tgt < cur) return cur - N'(1);
    else                return cur;
`else
    return (cur == tgt) ? cur : tgt;
`endif
  endfunction

  // Busy is still high during the done pulse, which keeps that IDLE cycle
  // from arbitrating; the following IDLE cycle is the sampling cycle.
  assign arb_en = (state == S_IDLE) && !busy;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req),
    .win (win),
    .idx (win_idx)
  );

  // Sequencer FSM: all outputs registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      q      <= '0;
      target <= '0;
      cnt    <= '0;
      gnt    <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (req != 2'b00) begin
            gnt    <= win;
            target <= (win_idx == REQ_B) ? code_b : code_a;
            busy   <= 1'b1;
            state  <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (q == target) begin
            state <= S_DONE;
          end else begin
            q     <= step(q, target);
            cnt   <= CNT_LOAD;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            state <= S_MOVE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Expected analog output
  assign vout_exp = code_to_volt(32'(q), VSUP, N);

endmodule

// File: tb/tb_dac_seq_ctrl.sv
`timescale 1ns/1ps
module tb_dac_seq_ctrl;

  localparam int  N    = 3;
  localparam int  S    = 4;
  localparam real VSUP = 1.0;
`ifdef DAC_SLEW_EN
  localparam bit  SLEW = 1'b1;
`else
  localparam bit  SLEW = 1'b0;
`endif
  // Code at which the mid-ramp reset is applied (ramping 0 -> 6).
  localparam logic [N-1:0] QR = SLEW ? 3'd2 : 3'd6;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [N-1:0] code_a, code_b;
  logic [1:0]   gnt;
  logic         busy, done;
  logic [N-1:0] q;
  real          vout_exp;

  always #5 clk = ~clk;

  dac_seq_ctrl #(.N(N), .SETTLE(S), .VSUP(VSUP)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .code_a   (code_a),
    .code_b   (code_b),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .vout_exp (vout_exp)
  );

  typedef struct {
    logic [1:0]   gnt;
    logic [N-1:0] q;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Cycles from the grant cycle to the done pulse for a distance of d codes.
  function automatic int lat_of(input int d);
    if (d == 0) return 2;
    if (SLEW)   return 2 + d * (S + 1);
    return 2 + (S + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkr(input string name, input real act, input real exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %f expected %f (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_x(input logic [1:0] g, input logic [N-1:0] qe, input int d);
    exp_t e;
    e.gnt = g;
    e.q   = qe;
    e.lat = lat_of(d);
    sbq.push_back(e);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each event.
  logic [N-1:0] prev_q = '0;
  int   g_cyc      = 0;
  int   last_evt   = 0;
  bit   first_step = 1'b0;
  bit   track      = 1'b0;
  bit   busy_chk   = 1'b0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      track    = 1'b0;
      busy_chk = 1'b0;
    end else begin
      if (busy_chk) begin
        chk("busy_after_done", 64'(busy), 64'd0);
        busy_chk = 1'b0;
      end
      if (gnt != 2'b00) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got %b expected none (cycle %0d)", gnt, cyc);
        end else begin
          chk("gnt", 64'(gnt), 64'(sbq[0].gnt));
          chk("busy_with_gnt", 64'(busy), 64'd1);
        end
        g_cyc      = cyc;
        last_evt   = cyc;
        first_step = 1'b1;
        track      = 1'b1;
      end
      if (track && (q != prev_q)) begin
        chk("step_gap", 64'(cyc - last_evt), first_step ? 64'd1 : 64'(S + 1));
`ifdef DAC_SLEW_EN
        chk("step_size", 64'((q > prev_q) ? (q - prev_q) : (prev_q - q)), 64'd1);
`endif
        last_evt   = cyc;
        first_step = 1'b0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          me = sbq.pop_front();
          chk("done_q", 64'(q), 64'(me.q));
          chkr("done_vout", vout_exp, real'(me.q) * VSUP / 8.0);
          chk("done_latency", 64'(cyc - g_cyc), 64'(me.lat));
        end
        busy_chk = 1'b1;
        track    = 1'b0;
      end
    end
    prev_q = q;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Requesters hold until granted; wait until every expected done is seen.
  task automatic run(input logic [1:0] r, input logic [N-1:0] ca, input logic [N-1:0] cb);
    int t;
    t      = 0;
    code_a = ca;
    code_b = cb;
    req    = r;
    while (((req != 2'b00) || (sbq.size() != 0)) && (t < 600)) begin
      tick();
      t++;
      if (gnt[0]) req[0] = 1'b0;
      if (gnt[1]) req[1] = 1'b0;
    end
    if (t >= 600) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending expected 0 (cycle %0d)", sbq.size(), cyc);
      sbq.delete();
      req = 2'b00;
    end
    tick();
    tick();
  endtask

  initial begin
    int t;
    rst    = 1'b1;
    req    = 2'b00;
    code_a = '0;
    code_b = '0;

    // Reset state
    do_reset(2);
    chk("rst_q", 64'(q), 64'd0);
    chkr("rst_vout", vout_exp, 0.0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Single ramp 0 -> 3 from A (0.375 V at done)
    expect_x(2'b01, 3'd3, 3);
    run(2'b01, 3'd3, 3'd0);

    // A won last, so reset to put A back in front, then simultaneous requests
    do_reset(2);
    expect_x(2'b01, 3'd7, 7);
    expect_x(2'b10, 3'd2, 5);
    run(2'b11, 3'd7, 3'd2);

    // B alone wins although the pointer favours A; then a zero-distance move
    expect_x(2'b10, 3'd5, 3);
    run(2'b10, 3'd0, 3'd5);
    expect_x(2'b10, 3'd5, 0);
    run(2'b10, 3'd0, 3'd5);

    // A no-op, after which B holds priority under contention
    expect_x(2'b01, 3'd5, 0);
    run(2'b01, 3'd5, 3'd0);
    expect_x(2'b10, 3'd6, 1);
    expect_x(2'b01, 3'd1, 5);
    run(2'b11, 3'd1, 3'd6);

    // Reset while ramping 0 -> 6 with A still requesting
    do_reset(2);
    code_a = 3'd6;
    req    = 2'b01;
    expect_x(2'b01, 3'd6, 6);
    t = 0;
    while ((q !== QR) && (t < 100)) begin
      tick();
      t++;
    end
    chk("midramp_reached", 64'(q), 64'(QR));
    rst = 1'b1;
    sbq.delete();
    tick();
    chk("midrst_q", 64'(q), 64'd0);
    chkr("midrst_vout", vout_exp, 0.0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    rst = 1'b0;
    expect_x(2'b01, 3'd6, 6);
    run(2'b01, 3'd6, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
